// File: rtl/gcd_pkg.sv
// Shared types and defaults for the subtractive GCD engine.
// Optional cycle reporting is enabled by defining GCD_CYCLES_EN.
package gcd_pkg;

  localparam int GCD_WIDTH = 8;

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    DONE
  } state_e;

endpackage

// File: rtl/gcd_step.sv
// One subtractive GCD iteration: compare the working pair and
// either finish with a result or reduce the larger operand.
module gcd_step
  import gcd_pkg::*;
#(
  parameter int WIDTH = GCD_WIDTH
) (
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  output logic [WIDTH-1:0] a_o,
  output logic [WIDTH-1:0] b_o,
  output logic [WIDTH-1:0] res_o,
  output logic             done_o,
  output logic             err_o
);

  always_comb begin
    a_o    = a_i;
    b_o    = b_i;
    res_o  = '0;
    done_o = 1'b0;
    err_o  = 1'b0;
    // Ordered checks; the compare guarantees no subtraction underflows
    if (a_i == '0 && b_i == '0) begin
      done_o = 1'b1;
      err_o  = 1'b1;
    end else if (a_i == '0) begin
      done_o = 1'b1;
      res_o  = b_i;
    end else if (b_i == '0) begin
      done_o = 1'b1;
      res_o  = a_i;
    end else if (a_i == b_i) begin
      done_o = 1'b1;
      res_o  = a_i;
    end else if (a_i > b_i) begin
      a_o = a_i - b_i;
    end else begin
      b_o = b_i - a_i;
    end
  end

endmodule

// File: rtl/gcd_engine.sv
// Valid/ready GCD engine: IDLE accepts a pair, CALC iterates gcd_step,
// DONE presents the result. Define GCD_CYCLES_EN to add out_cycles.
module gcd_engine
  import gcd_pkg::*;
#(
  parameter int WIDTH = GCD_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_gcd,
  output logic             out_err
`ifdef GCD_CYCLES_EN
  ,
  output logic [WIDTH-1:0] out_cycles
`endif
);

  state_e           state_q;
  logic [WIDTH-1:0] a_q, b_q, gcd_q;
  logic             err_q, valid_q;
  logic [WIDTH-1:0] a_d, b_d, res_d;
  logic             done_d, err_d;

  gcd_step #(.WIDTH(WIDTH)) u_step (
    .a_i    (a_q),
    .b_i    (b_q),
    .a_o    (a_d),
    .b_o    (b_d),
    .res_o  (res_d),
    .done_o (done_d),
    .err_o  (err_d)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      gcd_q   <= '0;
      err_q   <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (in_valid) begin
            a_q     <= in_a;
            b_q     <= in_b;
            state_q <= CALC;
          end
        end
        CALC: begin
          if (done_d) begin
            gcd_q   <= res_d;
            err_q   <= err_d;
            state_q <= DONE;
          end else begin
            a_q <= a_d;
            b_q <= b_d;
          end
        end
        DONE: begin
          // Result regs settle one cycle before valid is raised
          if (!valid_q) begin
            valid_q <= 1'b1;
          end else if (out_ready) begin
            valid_q <= 1'b0;
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = valid_q;
  assign out_gcd   = gcd_q;
  assign out_err   = err_q;

`ifdef GCD_CYCLES_EN
  logic [WIDTH-1:0] cnt_q, cyc_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
      cyc_q <= '0;
    end else begin
      if (state_q == IDLE && in_valid) begin
        cnt_q <= '0;
      end else if (state_q == CALC) begin
        cnt_q <= cnt_q + WIDTH'(1);
        if (done_d) cyc_q <= cnt_q + WIDTH'(1);
      end
    end
  end

  assign out_cycles = cyc_q;
`endif

endmodule

// File: tb/tb_gcd_engine.sv
// Scoreboard bench for gcd_engine at WIDTH=5.
// Cycle counts are checked only when built with GCD_CYCLES_EN.
module tb_gcd_engine;

  localparam int W = 5;

  typedef struct {
    int gcd;
    int err;
    int cyc;
  } exp_t;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [W-1:0] in_a = '0;
  logic [W-1:0] in_b = '0;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [W-1:0] out_gcd;
  logic         out_err;
`ifdef GCD_CYCLES_EN
  logic [W-1:0] out_cycles;
`endif

  int   n_cmp = 0;
  int   n_bad = 0;
  exp_t sb[$];

  gcd_engine #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_a      (in_a),
    .in_b      (in_b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_gcd   (out_gcd),
    .out_err   (out_err)
`ifdef GCD_CYCLES_EN
    ,
    .out_cycles(out_cycles)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int got, input int exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d want %0d", tag, got, exp);
    end
  endtask

  function automatic int euclid(input int a, input int b);
    int x = a;
    int y = b;
    int t;
    while (y != 0) begin
      t = x % y;
      x = y;
      y = t;
    end
    return x;
  endfunction

  function automatic exp_t model(input int a, input int b);
    exp_t e;
    int x = a;
    int y = b;
    int n = 1;
    while (!(x == 0 || y == 0 || x == y)) begin
      if (x > y) x -= y;
      else y -= x;
      n++;
    end
    e.gcd = euclid(a, b);
    e.err = (a == 0 && b == 0) ? 1 : 0;
    e.cyc = n;
    return e;
  endfunction

  task automatic run_pair(input int a, input int b, input int hold);
    exp_t e;
    int   lat;
    int   w;
    sb.push_back(model(a, b));
    w = 0;
    while (!in_ready && w < 100) begin
      @(posedge clk); #1; w++;
    end
    chk("in_ready_before", int'(in_ready), 1);
    in_a = W'(a); in_b = W'(b); in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    in_a = W'($urandom); in_b = W'($urandom);
    lat = 0;
    while (!out_valid && lat < 100) begin
      @(posedge clk); #1; lat++;
      if (lat == 1) begin in_a = W'($urandom); in_b = W'($urandom); end
    end
    e = sb.pop_front();
    chk($sformatf("lat(%0d,%0d)", a, b), lat, e.cyc + 1);
    chk($sformatf("gcd(%0d,%0d)", a, b), int'(out_gcd), e.gcd);
    chk($sformatf("err(%0d,%0d)", a, b), int'(out_err), e.err);
`ifdef GCD_CYCLES_EN
    chk($sformatf("cyc(%0d,%0d)", a, b), int'(out_cycles), e.cyc);
`endif
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      chk("hold_valid", int'(out_valid), 1);
      chk("hold_gcd", int'(out_gcd), e.gcd);
      chk("hold_rdy", int'(in_ready), 0);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk("post_rdy", int'(in_ready), 1);
    chk("post_valid", int'(out_valid), 0);
  endtask

  initial begin
    int seen;
    #3;
    chk("rst_valid", int'(out_valid), 0);
    chk("rst_gcd", int'(out_gcd), 0);
    chk("rst_err", int'(out_err), 0);
    @(negedge clk); rst = 1'b0;
    @(posedge clk); #1;
    chk("rst_rdy", int'(in_ready), 1);

    run_pair(31, 31, 2);
    run_pair(12, 18, 0);
    run_pair(18, 12, 0);
    run_pair(31, 1, 0);
    run_pair(0, 7, 0);
    run_pair(0, 0, 1);
    run_pair(9, 6, 10);
    run_pair(7, 5, 0);

    // Abort a long computation with an asynchronous reset
    in_a = 5'd31; in_b = 5'd1; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (5) @(posedge clk);
    #3 rst = 1'b1;
    #1;
    chk("abort_valid", int'(out_valid), 0);
    chk("abort_gcd", int'(out_gcd), 0);
    chk("abort_err", int'(out_err), 0);
`ifdef GCD_CYCLES_EN
    chk("abort_cyc", int'(out_cycles), 0);
`endif
    @(negedge clk); rst = 1'b0;
    seen = 0;
    repeat (40) begin
      @(posedge clk); #1;
      if (out_valid) seen = 1;
    end
    chk("abort_novalid", seen, 0);
    chk("abort_rdy", int'(in_ready), 1);
    run_pair(8, 4, 0);

    for (int i = 0; i < 6; i++)
      run_pair(int'($urandom_range(1, 31)), int'($urandom_range(1, 31)), 0);

    chk("sb_empty", sb.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
